// File: rtl/adc_ctrl_scan_fsm.sv
// ADC scan sequencer for adc_ctrl (always-on domain): power-up, masked channel scan with
// capture, LP/NP filter-match evaluation and oneshot. Define ADC_CTRL_SCAN_TIMEOUT_EN for the handshake watchdog.
module adc_ctrl_scan_fsm #(
    parameter int NumChn    = 2,
    parameter int DataW     = 10,
    parameter int NumFilter = 8,
    parameter int PwrupW    = 4,
    parameter int WakeupW   = 24
`ifdef ADC_CTRL_SCAN_TIMEOUT_EN
    ,
    parameter int TimeoutW  = 8
`endif
) (
    input  logic                    clk_aon_i,
    input  logic                    rst_aon_ni,
`ifdef ADC_CTRL_SCAN_TIMEOUT_EN
    input  logic [TimeoutW-1:0]     cfg_timeout_i,
    output logic                    timeout_err_o,
`endif
    input  logic                    cfg_fsm_rst_i,
    input  logic                    cfg_adc_enable_i,
    input  logic                    cfg_oneshot_mode_i,
    input  logic                    cfg_lp_mode_i,
    input  logic [NumChn-1:0]       cfg_chn_en_i,
    input  logic [PwrupW-1:0]       cfg_pwrup_time_i,
    input  logic [WakeupW-1:0]      cfg_wakeup_time_i,
    input  logic [7:0]              cfg_lp_sample_cnt_i,
    input  logic [15:0]             cfg_np_sample_cnt_i,
    input  logic [NumFilter-1:0]    adc_ctrl_match_i,
    input  logic [DataW-1:0]        adc_d_i,
    input  logic                    adc_d_val_i,
    output logic                    adc_pd_o,
    output logic [NumChn-1:0]       adc_chn_sel_o,
    output logic [NumChn-1:0]       chn_val_we_o,
    output logic [NumChn*DataW-1:0] chn_val_o,
    output logic                    adc_ctrl_done_o,
    output logic                    oneshot_done_o
);
    localparam int IdxW = (NumChn > 1) ? $clog2(NumChn) : 1;

    typedef enum logic [3:0] {
        ST_PWRDN, ST_PWRUP, ST_SEL, ST_GAP, ST_ONEST_DONE,
        ST_EVAL, ST_NP_DONE, ST_LP_SLP, ST_LP_PWRUP
    } state_e;
    typedef enum logic [1:0] {MODE_ONESHOT, MODE_LP, MODE_NP} mode_e;
    typedef struct packed {
        logic            found;
        logic [IdxW-1:0] idx;
    } chn_pick_t;

    // Lowest enabled channel at or above start.
    function automatic chn_pick_t pick_chn(input logic [NumChn-1:0] mask, input int start);
        chn_pick_t p;
        p.found = 1'b0;
        p.idx   = '0;
        for (int i = NumChn - 1; i >= 0; i--) begin
            if (mask[i] && i >= start) begin
                p.found = 1'b1;
                p.idx   = IdxW'(i);
            end
        end
        return p;
    endfunction

    state_e               r_state, w_state_nxt;
    mode_e                r_mode, w_mode_nxt;
    logic                 r_trigger_q;
    logic [IdxW-1:0]      r_chn_idx, w_chn_idx_nxt;
    logic [PwrupW-1:0]    r_pwrup_cnt, w_pwrup_cnt_nxt;
    logic [WakeupW-1:0]   r_wakeup_cnt, w_wakeup_cnt_nxt;
    logic [7:0]           r_lp_cnt, w_lp_cnt_nxt;
    logic [15:0]          r_np_cnt, w_np_cnt_nxt;
    logic [NumFilter-1:0] r_match_q, w_match_nxt;
    logic [NumChn*DataW-1:0] r_chn_val;
    logic [NumChn-1:0]    r_chn_val_we;
    logic                 w_capture, w_np_done, w_onest_done;
    logic [NumChn-1:0]    w_chn_onehot;
    chn_pick_t            w_first, w_next;
    logic                 w_rise, w_fall, w_stay;
    logic [7:0]           w_lp_thr;
    logic [15:0]          w_np_thr;
`ifdef ADC_CTRL_SCAN_TIMEOUT_EN
    logic [TimeoutW-1:0]  r_to_cnt, w_to_cnt_nxt;
    logic                 r_timeout_err, w_to_hit;
`endif

    assign w_rise       = cfg_adc_enable_i & ~r_trigger_q;
    assign w_fall       = ~cfg_adc_enable_i & r_trigger_q;
    assign w_first      = pick_chn(cfg_chn_en_i, 0);
    assign w_next       = pick_chn(cfg_chn_en_i, int'(r_chn_idx) + 1);
    assign w_chn_onehot = NumChn'(1) << r_chn_idx;
    assign w_lp_thr     = cfg_lp_sample_cnt_i - 8'd1;
    assign w_np_thr     = cfg_np_sample_cnt_i - 16'd1;
    // An empty previous match counts as agreement so the very first hit can start a run.
    assign w_stay       = (|adc_ctrl_match_i) &&
                          ((adc_ctrl_match_i == r_match_q) || !(|r_match_q));

    // NOTE: every signal gets a default before the case so no path can infer a latch.
    always_comb begin
        w_state_nxt      = r_state;
        w_mode_nxt       = r_mode;
        w_chn_idx_nxt    = r_chn_idx;
        w_pwrup_cnt_nxt  = r_pwrup_cnt;
        w_wakeup_cnt_nxt = r_wakeup_cnt;
        w_lp_cnt_nxt     = r_lp_cnt;
        w_np_cnt_nxt     = r_np_cnt;
        w_match_nxt      = r_match_q;
        w_capture        = 1'b0;
        w_np_done        = 1'b0;
        w_onest_done     = 1'b0;
        case (r_state)
            ST_PWRDN: if (w_rise) w_state_nxt = ST_PWRUP;
            ST_PWRUP, ST_LP_PWRUP: begin
                if (r_pwrup_cnt != cfg_pwrup_time_i) begin
                    w_pwrup_cnt_nxt = r_pwrup_cnt + 1'b1;
                end else begin
                    w_pwrup_cnt_nxt = '0;
                    if (w_first.found) begin
                        w_chn_idx_nxt = w_first.idx;
                        w_state_nxt   = ST_SEL;
                        if (r_state == ST_PWRUP)
                            w_mode_nxt = cfg_oneshot_mode_i ? MODE_ONESHOT :
                                         (cfg_lp_mode_i ? MODE_LP : MODE_NP);
                    end
                end
            end
            ST_SEL: if (adc_d_val_i) begin
                w_capture   = 1'b1;
                w_state_nxt = ST_GAP;
            end
            ST_GAP: if (!adc_d_val_i) begin
                if (w_next.found) begin
                    w_chn_idx_nxt = w_next.idx;
                    w_state_nxt   = ST_SEL;
                end else begin
                    w_state_nxt = (r_mode == MODE_ONESHOT) ? ST_ONEST_DONE : ST_EVAL;
                end
            end
            ST_ONEST_DONE: begin
                w_onest_done = 1'b1;
                w_state_nxt  = ST_PWRDN;
            end
            ST_EVAL: begin
                w_match_nxt   = adc_ctrl_match_i;
                w_chn_idx_nxt = w_first.idx;
                // A new scan with an empty mask waits in PWRUP until a channel is enabled.
                w_state_nxt   = w_first.found ? ST_SEL : ST_PWRUP;
                if (r_mode == MODE_LP) begin
                    if (w_stay && r_lp_cnt < w_lp_thr) begin
                        w_lp_cnt_nxt = r_lp_cnt + 8'd1;
                        w_state_nxt  = ST_LP_SLP;
                    end else if (w_stay) begin
                        w_lp_cnt_nxt = '0;
                        w_mode_nxt   = MODE_NP;
                    end else begin
                        w_lp_cnt_nxt = '0;
                        w_state_nxt  = ST_LP_SLP;
                    end
                end else begin
                    if (!w_stay) begin
                        w_np_cnt_nxt = '0;
                    end else if (r_np_cnt < w_np_thr) begin
                        w_np_cnt_nxt = r_np_cnt + 16'd1;
                    end else if (r_np_cnt == w_np_thr) begin
                        w_np_cnt_nxt = r_np_cnt + 16'd1;
                        w_state_nxt  = ST_NP_DONE;
                    end
                end
            end
            ST_NP_DONE: begin
                w_np_done     = 1'b1;
                w_chn_idx_nxt = w_first.idx;
                w_state_nxt   = w_first.found ? ST_SEL : ST_PWRUP;
            end
            ST_LP_SLP: begin
                if (r_wakeup_cnt != cfg_wakeup_time_i) begin
                    w_wakeup_cnt_nxt = r_wakeup_cnt + 1'b1;
                end else begin
                    w_wakeup_cnt_nxt = '0;
                    w_state_nxt      = ST_LP_PWRUP;
                end
            end
            default: w_state_nxt = ST_PWRDN;
        endcase
`ifdef ADC_CTRL_SCAN_TIMEOUT_EN
        w_to_hit     = 1'b0;
        w_to_cnt_nxt = '0;
        if (r_state == ST_SEL || r_state == ST_GAP) begin
            if (cfg_timeout_i != '0 && r_to_cnt == cfg_timeout_i - 1'b1) begin
                w_to_hit    = 1'b1;
                w_capture   = 1'b0;
                w_state_nxt = ST_PWRDN;
            end else if (!(r_state == ST_GAP && w_state_nxt == ST_SEL)) begin
                w_to_cnt_nxt = r_to_cnt + 1'b1;
            end
        end
`endif
        // Abort wins over everything, including a done pulse in the same cycle.
        if (w_fall || cfg_fsm_rst_i) begin
            w_state_nxt      = ST_PWRDN;
            w_chn_idx_nxt    = '0;
            w_pwrup_cnt_nxt  = '0;
            w_wakeup_cnt_nxt = '0;
            w_lp_cnt_nxt     = '0;
            w_np_cnt_nxt     = '0;
            w_capture        = 1'b0;
            w_np_done        = 1'b0;
            w_onest_done     = 1'b0;
            if (cfg_fsm_rst_i) w_match_nxt = '0;
`ifdef ADC_CTRL_SCAN_TIMEOUT_EN
            w_to_cnt_nxt = '0;
            w_to_hit     = 1'b0;
`endif
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_aon_i or negedge rst_aon_ni) begin
        if (!rst_aon_ni) begin
            r_state      <= ST_PWRDN;
            r_mode       <= MODE_NP;
            r_trigger_q  <= 1'b0;
            r_chn_idx    <= '0;
            r_pwrup_cnt  <= '0;
            r_wakeup_cnt <= '0;
            r_lp_cnt     <= '0;
            r_np_cnt     <= '0;
            r_match_q    <= '0;
            r_chn_val    <= '0;
            r_chn_val_we <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_mode       <= w_mode_nxt;
            r_trigger_q  <= cfg_adc_enable_i;
            r_chn_idx    <= w_chn_idx_nxt;
            r_pwrup_cnt  <= w_pwrup_cnt_nxt;
            r_wakeup_cnt <= w_wakeup_cnt_nxt;
            r_lp_cnt     <= w_lp_cnt_nxt;
            r_np_cnt     <= w_np_cnt_nxt;
            r_match_q    <= w_match_nxt;
            r_chn_val_we <= w_capture ? w_chn_onehot : '0;
            if (cfg_fsm_rst_i) r_chn_val <= '0;
            else if (w_capture) r_chn_val[int'(r_chn_idx)*DataW +: DataW] <= adc_d_i;
        end
    end

`ifdef ADC_CTRL_SCAN_TIMEOUT_EN
    always_ff @(posedge clk_aon_i or negedge rst_aon_ni) begin
        if (!rst_aon_ni) begin
            r_to_cnt      <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_to_cnt <= w_to_cnt_nxt;
            if (cfg_fsm_rst_i) r_timeout_err <= 1'b0;
            else if (w_to_hit) r_timeout_err <= 1'b1;
        end
    end
    assign timeout_err_o = r_timeout_err;
`endif

    assign adc_pd_o        = (r_state == ST_PWRDN) || (r_state == ST_LP_SLP);
    assign adc_chn_sel_o   = (r_state == ST_SEL) ? w_chn_onehot : '0;
    assign chn_val_we_o    = r_chn_val_we;
    assign chn_val_o       = r_chn_val;
    assign adc_ctrl_done_o = w_np_done;
    assign oneshot_done_o  = w_onest_done;

    a_lp_thr_nonzero: assert property (@(posedge clk_aon_i) disable iff (!rst_aon_ni)
        (r_state == ST_EVAL && r_mode == MODE_LP) |-> cfg_lp_sample_cnt_i != 8'd0);
    a_np_thr_nonzero: assert property (@(posedge clk_aon_i) disable iff (!rst_aon_ni)
        (r_state == ST_EVAL && r_mode == MODE_NP) |-> cfg_np_sample_cnt_i != 16'd0);
endmodule
